// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port main memory between the instruction cache (read-only
// fills) and the data cache (fills and writebacks). Only one transaction is in
// flight at a time. The data side normally wins a tie. The fetch side is
// forced through after STARVE_MAX consecutive D grants made while it waited.
//
// Transaction flow: IDLE -> ISSUE (one mem_en strobe) -> WAIT (MEM_LAT cycles)
// -> ACK (one-cycle ack to the owner) -> IDLE.
//
// Parameters
//   MEM_LAT     cycles from the mem_en cycle to valid mem_rdata (1..15)
//   STARVE_MAX  D grants tolerated while i_req is pending (1..15)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_req/i_addr        instruction read request (held until i_ack)
//   i_ack/i_rdata       one-cycle completion pulse, read data (0 otherwise)
//   d_req/d_wr/d_addr/  data request, write flag, address, write data
//   d_wdata
//   d_ack/d_rdata       one-cycle completion pulse, read data (0 on writes)
//   mem_en/mem_wr       memory strobe and its write qualifier
//   mem_addr/mem_wdata  latched address / write data (qualified by mem_en)
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   busy                arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam logic [3:0] WAIT_LOAD  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_grant;
    logic        w_grant_d;

    logic        r_owner_d;     // 1 = data side owns the current transaction
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_rdata;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_d_streak;    // consecutive D grants made while I waited

    // -------------------------------------------------------------------------
    // Next-state, grant decision and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        mem_en       = 1'b0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (d_req && i_req) begin
                    // D wins the tie unless I has already waited too long.
                    w_grant   = 1'b1;
                    w_grant_d = (r_d_streak != STREAK_MAX);
                end else if (d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = 1'b1;
                end else if (i_req) begin
                    w_grant   = 1'b1;
                end
                if (w_grant) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en       = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                i_ack        = ~r_owner_d;
                d_ack        = r_owner_d;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: latched request fields, wait counter, read data, D streak
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset too, because mem_addr/mem_wdata/mem_wr
        // drive ports straight from these registers and must read 0 in reset.
        if (rst) begin
            r_owner_d   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_wait_cnt  <= '0;
            r_d_streak  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner_d   <= w_grant_d;
                        r_mem_addr  <= w_grant_d ? d_addr : i_addr;
                        r_mem_wr    <= w_grant_d & d_wr;
                        r_mem_wdata <= w_grant_d ? d_wdata : 16'd0;
                        // The streak only grows while the fetch side is
                        // actually being passed over.
                        if (w_grant_d && i_req) begin
                            if (r_d_streak != STREAK_MAX) begin
                                r_d_streak <= r_d_streak + 4'd1;
                            end
                        end else begin
                            r_d_streak <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        // Writes complete with zero read data.
                        r_rdata <= r_mem_wr ? 16'd0 : mem_rdata;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Read data is only presented alongside its ack.
    assign i_rdata = i_ack ? r_rdata : 16'd0;
    assign d_rdata = d_ack ? r_rdata : 16'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Three arbiter instances share address/data stimulus but have private request
// lines: instance 0 uses MEM_LAT=2, instance 1 MEM_LAT=1, instance 2 MEM_LAT=5.
// A behavioural memory returns addr ^ 16'hA5E5 exactly MEM_LAT cycles after
// each strobe and junk on every other cycle. Expected memory strobes and acks
// are queued when stimulus is driven and compared as the DUTs produce them.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hA5E5;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_v  [NI];
    logic        d_req_v  [NI];
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_wr;

    logic        i_ack_v     [NI];
    logic        d_ack_v     [NI];
    logic        mem_en_v    [NI];
    logic        mem_wr_v    [NI];
    logic        busy_v      [NI];
    logic [15:0] i_rdata_v   [NI];
    logic [15:0] d_rdata_v   [NI];
    logic [15:0] mem_addr_v  [NI];
    logic [15:0] mem_wdata_v [NI];
    logic [15:0] mem_rdata_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .MEM_LAT    ((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
            .STARVE_MAX (3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req_v[g]),
            .i_addr    (i_addr),
            .i_ack     (i_ack_v[g]),
            .i_rdata   (i_rdata_v[g]),
            .d_req     (d_req_v[g]),
            .d_wr      (d_wr),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ack     (d_ack_v[g]),
            .d_rdata   (d_rdata_v[g]),
            .mem_en    (mem_en_v[g]),
            .mem_wr    (mem_wr_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata_v[g]),
            .busy      (busy_v[g])
        );
    end

    typedef struct {
        int          inst;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          inst;
        logic        is_d;
        logic [15:0] rdata;
        int          cyc;
    } ack_exp_t;

    mem_exp_t    mem_q[$];
    ack_exp_t    ack_q[$];

    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          due_v        [NI];
    logic [15:0] data_v       [NI];
    int          ack_seen_v   [NI];
    int          last_ack_cyc [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model plus scoreboard monitor, sampled 1 ns after each edge.
    always @(posedge clk) begin : mon
        mem_exp_t    me;
        ack_exp_t    ae;
        logic        got_d;
        logic [15:0] got_rd;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (due_v[k] == cyc) mem_rdata_v[k] = data_v[k];
            else                 mem_rdata_v[k] = 16'hDEAD ^ 16'(cyc);

            if (mem_en_v[k] === 1'b1) begin
                total_cnt++;
                if (mem_q.size() == 0) begin
                    $display("FAIL mem_issue inst=%0d cyc=%0d: got unexpected strobe addr=%h, required none",
                             k, cyc, mem_addr_v[k]);
                end else begin
                    me = mem_q.pop_front();
                    if (me.inst != k || mem_wr_v[k] !== me.wr || mem_addr_v[k] !== me.addr ||
                        (me.wr && mem_wdata_v[k] !== me.wdata)) begin
                        $display("FAIL mem_issue inst=%0d cyc=%0d: got wr=%b addr=%h wdata=%h, required inst=%0d wr=%b addr=%h wdata=%h",
                                 k, cyc, mem_wr_v[k], mem_addr_v[k], mem_wdata_v[k],
                                 me.inst, me.wr, me.addr, me.wdata);
                    end else begin
                        pass_cnt++;
                    end
                end
                due_v[k]  = cyc + lat_of(k);
                data_v[k] = mem_fn(mem_addr_v[k]);
            end

            if (i_ack_v[k] === 1'b1 || d_ack_v[k] === 1'b1) begin
                total_cnt++;
                got_d  = d_ack_v[k];
                got_rd = got_d ? d_rdata_v[k] : i_rdata_v[k];
                if (i_ack_v[k] === 1'b1 && d_ack_v[k] === 1'b1) begin
                    $display("FAIL ack_both inst=%0d cyc=%0d: got i_ack=1 d_ack=1, required one", k, cyc);
                end else if (ack_q.size() == 0) begin
                    $display("FAIL ack_unexpected inst=%0d cyc=%0d: got d=%b rdata=%h, required no ack",
                             k, cyc, got_d, got_rd);
                end else begin
                    ae = ack_q.pop_front();
                    if (ae.inst != k || got_d !== ae.is_d || got_rd !== ae.rdata ||
                        (ae.cyc >= 0 && ae.cyc != cyc)) begin
                        $display("FAIL ack inst=%0d: got d=%b rdata=%h cyc=%0d, required inst=%0d d=%b rdata=%h cyc=%0d",
                                 k, got_d, got_rd, cyc, ae.inst, ae.is_d, ae.rdata, ae.cyc);
                    end else begin
                        pass_cnt++;
                    end
                end
                ack_seen_v[k]++;
                last_ack_cyc[k] = cyc;
            end else begin
                total_cnt++;
                if (i_rdata_v[k] !== 16'd0 || d_rdata_v[k] !== 16'd0) begin
                    $display("FAIL rdata_idle inst=%0d cyc=%0d: got i_rdata=%h d_rdata=%h, required 0",
                             k, cyc, i_rdata_v[k], d_rdata_v[k]);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    function automatic logic [68:0] outs_of(input int k);
        return {i_ack_v[k], d_ack_v[k], mem_en_v[k], mem_wr_v[k], busy_v[k],
                i_rdata_v[k], d_rdata_v[k], mem_addr_v[k], mem_wdata_v[k]};
    endfunction

    task automatic wait_ack(input int k, input int budget, output bit ok, output int at);
        int start;
        start = ack_seen_v[k];
        ok    = 1'b0;
        at    = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if (ack_seen_v[k] != start) begin
                ok = 1'b1;
                at = last_ack_cyc[k];
                break;
            end
        end
    endtask

    // One isolated transaction on instance k with the normal latency expected.
    task automatic do_txn(input int k, input logic is_d, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata);
        int       t;
        int       at;
        bit       ok;
        mem_exp_t me;
        ack_exp_t ae;
        @(posedge clk); #2;
        t = cyc;
        if (is_d) begin
            d_wr = wr; d_addr = addr; d_wdata = wdata; d_req_v[k] = 1'b1;
        end else begin
            i_addr = addr; i_req_v[k] = 1'b1;
        end
        me = '{inst: k, wr: is_d & wr, addr: addr, wdata: wdata};
        mem_q.push_back(me);
        ae = '{inst: k, is_d: is_d, rdata: (is_d && wr) ? 16'd0 : mem_fn(addr),
               cyc: t + 2 + lat_of(k)};
        ack_q.push_back(ae);
        wait_ack(k, 30, ok, at);
        total_cnt++;
        if (!ok) $display("FAIL txn_timeout inst=%0d addr=%h: got no ack in 30 cycles, required ack", k, addr);
        else     pass_cnt++;
        @(posedge clk); #2;
        if (is_d) d_req_v[k] = 1'b0;
        else      i_req_v[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            total_cnt++;
            if (outs_of(k) !== '0) $display("FAIL reset_outputs inst=%0d: got %h, required 0", k, outs_of(k));
            else                   pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_i_read;
        int       t;
        logic     eb;
        mem_exp_t me;
        ack_exp_t ae;
        @(posedge clk); #2;
        t = cyc;
        total_cnt++;
        if (busy_v[0] !== 1'b0) $display("FAIL i_read_busy0: got %b, required 0", busy_v[0]);
        else                    pass_cnt++;
        i_addr = 16'h0040;
        i_req_v[0] = 1'b1;
        me = '{inst: 0, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000};
        mem_q.push_back(me);
        ae = '{inst: 0, is_d: 1'b0, rdata: 16'hA5A5, cyc: t + 4};
        ack_q.push_back(ae);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #2;
            if (c == 5) i_req_v[0] = 1'b0;
            eb = (c <= 4);
            total_cnt++;
            if (busy_v[0] !== eb) $display("FAIL i_read_busy cycle=%0d: got %b, required %b", c, busy_v[0], eb);
            else                  pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (mem_en_v[0] !== 1'b1 || mem_addr_v[0] !== 16'h0040 || mem_wr_v[0] !== 1'b0)
                    $display("FAIL i_read_issue: got en=%b addr=%h wr=%b, required en=1 addr=0040 wr=0",
                             mem_en_v[0], mem_addr_v[0], mem_wr_v[0]);
                else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++;
                if (i_ack_v[0] !== 1'b1 || i_rdata_v[0] !== 16'hA5A5)
                    $display("FAIL i_read_ack: got ack=%b rdata=%h, required ack=1 rdata=a5a5",
                             i_ack_v[0], i_rdata_v[0]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_d_write;
        do_txn(0, 1'b1, 1'b1, 16'h1000, 16'hBEEF);
    endtask

    task automatic test_contention;
        int       t;
        int       ad;
        int       ai;
        bit       okd;
        bit       oki;
        mem_exp_t me;
        ack_exp_t ae;
        @(posedge clk); #2;
        t = cyc;
        d_wr = 1'b0; d_addr = 16'h2000; i_addr = 16'h0080;
        d_req_v[0] = 1'b1; i_req_v[0] = 1'b1;
        me = '{inst: 0, wr: 1'b0, addr: 16'h2000, wdata: 16'h0000}; mem_q.push_back(me);
        me = '{inst: 0, wr: 1'b0, addr: 16'h0080, wdata: 16'h0000}; mem_q.push_back(me);
        ae = '{inst: 0, is_d: 1'b1, rdata: mem_fn(16'h2000), cyc: t + 4}; ack_q.push_back(ae);
        ae = '{inst: 0, is_d: 1'b0, rdata: mem_fn(16'h0080), cyc: t + 9}; ack_q.push_back(ae);
        wait_ack(0, 20, okd, ad);
        @(posedge clk); #2;
        d_req_v[0] = 1'b0;
        wait_ack(0, 20, oki, ai);
        @(posedge clk); #2;
        i_req_v[0] = 1'b0;
        total_cnt++;
        if (!okd || !oki || (ai - ad) != 5)
            $display("FAIL contention_gap: got d_ok=%b i_ok=%b gap=%0d, required gap 5", okd, oki, ai - ad);
        else pass_cnt++;
    endtask

    task automatic test_starve;
        int          t;
        int          n0;
        logic        is_d;
        logic [15:0] a;
        mem_exp_t    me;
        ack_exp_t    ae;
        @(posedge clk); #2;
        t = cyc;
        d_wr = 1'b0; d_addr = 16'h3000; i_addr = 16'h0100;
        d_req_v[0] = 1'b1; i_req_v[0] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            is_d = ((n % 4) != 3);
            a    = is_d ? 16'h3000 : 16'h0100;
            me = '{inst: 0, wr: 1'b0, addr: a, wdata: 16'h0000};
            mem_q.push_back(me);
            ae = '{inst: 0, is_d: is_d, rdata: mem_fn(a), cyc: t + 4 + 5 * n};
            ack_q.push_back(ae);
        end
        n0 = ack_seen_v[0];
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #2;
            if (ack_seen_v[0] - n0 >= 8) break;
        end
        @(posedge clk); #2;
        d_req_v[0] = 1'b0; i_req_v[0] = 1'b0;
        total_cnt++;
        if (ack_seen_v[0] - n0 != 8) $display("FAIL starve_count: got %0d acks, required 8", ack_seen_v[0] - n0);
        else                         pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int       t;
        int       n0;
        mem_exp_t me;
        @(posedge clk); #2;
        t = cyc;
        d_wr = 1'b0; d_addr = 16'h4000; d_req_v[0] = 1'b1;
        me = '{inst: 0, wr: 1'b0, addr: 16'h4000, wdata: 16'h0000};
        mem_q.push_back(me);
        repeat (2) @(posedge clk);
        #2;
        total_cnt++;
        if (busy_v[0] !== 1'b1 || mem_en_v[0] !== 1'b0)
            $display("FAIL reset_mid_wait: got busy=%b en=%b, required busy=1 en=0", busy_v[0], mem_en_v[0]);
        else pass_cnt++;
        rst = 1'b1;
        d_req_v[0] = 1'b0;
        n0 = ack_seen_v[0];
        @(posedge clk); #2;
        total_cnt++;
        if (outs_of(0) !== '0) $display("FAIL reset_mid_outputs: got %h, required 0", outs_of(0));
        else                   pass_cnt++;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        total_cnt++;
        if (ack_seen_v[0] != n0) $display("FAIL reset_mid_noack: got %0d acks, required 0", ack_seen_v[0] - n0);
        else                     pass_cnt++;
        do_txn(0, 1'b0, 1'b0, 16'h0200, 16'h0000);
    endtask

    task automatic test_latency;
        do_txn(1, 1'b0, 1'b0, 16'h0300, 16'h0000);
        do_txn(2, 1'b1, 1'b0, 16'h0400, 16'h0000);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wr = 1'b0;
        for (int k = 0; k < NI; k++) begin
            i_req_v[k] = 1'b0; d_req_v[k] = 1'b0;
            mem_rdata_v[k] = '0; due_v[k] = -1; data_v[k] = '0;
            ack_seen_v[k] = 0; last_ack_cyc[k] = -1;
        end

        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_starve();
        test_reset_mid();
        test_latency();

        repeat (4) @(posedge clk);
        #2;
        total_cnt++;
        if (mem_q.size() != 0 || ack_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d strobes and %0d acks outstanding, required 0",
                     mem_q.size(), ack_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port main memory between the instruction cache (read-only fills) and the data cache (fills and writebacks).
- Sits between both cache controllers and the memory module inside proc_hier.
- Serialises one transaction at a time.
- Gives data-side priority, with an anti-starvation guard for the fetch side.

Parameters:
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid (range 1..15).
- STARVE_MAX, 3, consecutive D grants allowed while i_req is pending before I is forced (range 1..15).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  instruction-side read request; held until i_ack.
- i_addr  in  16  instruction read address.
- i_ack  out  1  one-cycle pulse: I transaction complete.
- i_rdata  out  16  read data; valid only while i_ack=1.
- d_req  in  1  data-side request; held until d_ack.
- d_wr  in  1  1 = write, 0 = read; stable while d_req=1.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_ack  out  1  one-cycle pulse: D transaction complete.
- d_rdata  out  16  read data; valid only while d_ack=1; 0 on write acks.
- mem_en  out  1  one-cycle memory strobe.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  latched address.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  memory read data; valid exactly MEM_LAT cycles after the mem_en cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, d_streak 0.
  - Takes effect on the next posedge regardless of state.
  - An in-flight transaction is abandoned: no ack is issued and late mem_rdata is ignored.
- States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - If d_req and i_req are both high: grant D unless d_streak == STARVE_MAX, in which case grant I.
  - Else grant whichever single requester is high.
  - No request: stay in IDLE.
  - On grant: latch owner, addr, wr (I always read), wdata; go to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle with latched mem_wr/mem_addr/mem_wdata; load wait counter with MEM_LAT-1; go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, sample mem_rdata (reads) into the owner's rdata register and go to ACK.
- ACK: the owner's ack is high for one cycle with rdata valid; next state IDLE. The other ack stays 0.
- Latency: request seen in IDLE at cycle t gives mem_en at t+1, mem_rdata at t+1+MEM_LAT, ack at t+2+MEM_LAT.
  - The same latency applies to writes.
  - Throughput: at most one transaction per MEM_LAT+3 cycles.
- Back-to-back: a req still high in the IDLE cycle after its ack counts as a new request. Requesters drop req on the edge ending their ack cycle.
- d_streak:
  - +1 (saturating at STARVE_MAX) on a D grant while i_req=1.
  - Cleared on any I grant, or on a D grant with i_req=0.
- Requests changing while not in IDLE are ignored. Latched fields keep mem_* stable even if requester inputs change.
- mem_addr/mem_wdata/mem_wr may hold stale values when mem_en=0. Only mem_en qualifies them.
- i_rdata/d_rdata return to 0 when their ack is low.

Test Plan:
- Reset, then i_req=1, i_addr=0x0040, memory returns 0xA5A5 -> mem_en at cycle 1 with addr 0x0040, mem_wr=0; i_ack=1, i_rdata=0xA5A5 at cycle 4 (MEM_LAT=2); busy 1 for cycles 1-4.
- d_req=1, d_wr=1, d_addr=0x1000, d_wdata=0xBEEF -> one mem_en with mem_wr=1, addr 0x1000, data 0xBEEF; d_ack at cycle 4 with d_rdata=0; i_ack stays 0.
- i_req and d_req raised in the same cycle, D read of 0x2000 -> D served first; I served in the next transaction; I acks 5 cycles after D's ack.
- d_req held continuously (re-asserted after each ack) with i_req held, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; d_streak clears after each I grant.
- rst asserted during WAIT of a D read -> next cycle all outputs 0, no d_ack ever; state IDLE; a fresh i_req afterwards completes with normal latency.
- MEM_LAT=1 and MEM_LAT=5 builds with a single read each -> ack at t+3 and t+7 respectively; rdata equals mem_rdata sampled exactly MEM_LAT cycles after mem_en.
